regfile_sb: RTL and testbench

- Parametrised successor to the core integer register file: XLEN-wide, NREGS-deep, two combinational read ports, one write-back port.
- Adds write-to-read bypass, a per-register pending scoreboard for hazard detection, and a multi-cycle bulk-clear sequencer.
- Sits between decode (read/allocate) and write-back (ALU or data-memory result).

---
 rtl/regfile_sb.sv | 139 +++++++++++++
 tb/tb_regfile_sb.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: XLEN x NREGS integer register file with two combinational
// read ports and one write-back port. It also provides same-cycle
// write-to-read bypass, a per-register pending scoreboard, and a
// multi-cycle sequencer that clears the whole array.
module regfile_sb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned AW      = 5,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            alloc_we,
  input  logic [AW-1:0]   alloc_addr,
  input  logic            clr_req,
  output logic            clr_busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_clr_busy;
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;

  logic             w_idle;
  logic             w_wb_ok;
  logic             w_alloc_ok;
  logic             w_byp1;
  logic             w_byp2;
  logic             w_zero1;
  logic             w_zero2;
  logic [NREGS-1:0] w_pend_nxt;

  // Qualify write-back and allocate: both are dropped while clearing, and r0 is hard-wired when ZERO_R0 is set
  assign w_idle     = (r_state == ST_IDLE);
  assign w_wb_ok    = w_idle && wb_we && !(ZERO_R0 && (wb_addr == '0));
  assign w_alloc_ok = w_idle && alloc_we && !(ZERO_R0 && (alloc_addr == '0));

  // Bypass applies only in IDLE; the r0 override takes priority over bypass
  assign w_byp1  = BYPASS && w_idle && wb_we && (wb_addr == rs1_addr);
  assign w_byp2  = BYPASS && w_idle && wb_we && (wb_addr == rs2_addr);
  assign w_zero1 = ZERO_R0 && (rs1_addr == '0);
  assign w_zero2 = ZERO_R0 && (rs2_addr == '0);

  // Combinational read ports
  assign rs1_data = w_zero1 ? '0 : (w_byp1 ? wb_data : r_regs[rs1_addr]);
  assign rs2_data = w_zero2 ? '0 : (w_byp2 ? wb_data : r_regs[rs2_addr]);

  // A port is not busy when it is served by bypass or reads hard-wired r0
  assign rs1_busy = r_pend[rs1_addr] & ~w_byp1 & ~w_zero1;
  assign rs2_busy = r_pend[rs2_addr] & ~w_byp2 & ~w_zero2;

  assign clr_busy = r_clr_busy;

  // Next scoreboard state: clear sweeps one bit per cycle; otherwise write-back clears and allocate sets (set wins)
  always_comb begin
    w_pend_nxt = r_pend;
    if (r_state == ST_CLEAR) begin
      w_pend_nxt[r_cnt] = 1'b0;
    end else begin
      if (wb_we) begin
        w_pend_nxt[wb_addr] = 1'b0;
      end
      if (w_alloc_ok) begin
        w_pend_nxt[alloc_addr] = 1'b1;
      end
    end
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  // Register array: a clear sweep or a qualified write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_state == ST_CLEAR) begin
      r_regs[r_cnt] <= '0;
    end else if (w_wb_ok) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Clear sequencer: IDLE -> CLEAR on clr_req; sweeps 0..NREGS-1, then returns to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_clr_busy <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr_req) begin
            r_state    <= ST_CLEAR;
            r_cnt      <= '0;
            r_clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_IDX) begin
            r_state    <= ST_IDLE;
            r_clr_busy <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed vector table, clear and reset sequences,
// random traffic checked against a reference model, and a 64-bit/16-entry
// instance with bypass disabled.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic [4:0]  rs1_addr, rs2_addr, wb_addr, alloc_addr;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        rs1_busy, rs2_busy, wb_we, alloc_we, clr_req, clr_busy;

  regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .alloc_we(alloc_we), .alloc_addr(alloc_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  // Swept instance: XLEN=64, NREGS=16, no bypass
  logic [3:0]  s_rs1_addr, s_rs2_addr, s_wb_addr, s_alloc_addr;
  logic [63:0] s_rs1_data, s_rs2_data, s_wb_data;
  logic        s_rs1_busy, s_rs2_busy, s_wb_we, s_alloc_we, s_clr_req, s_clr_busy;

  regfile_sb #(.XLEN(64), .NREGS(16), .AW(4), .ZERO_R0(1'b1), .BYPASS(1'b0)) u_sweep (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(s_rs1_addr), .rs2_addr(s_rs2_addr),
    .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
    .rs1_busy(s_rs1_busy), .rs2_busy(s_rs2_busy),
    .wb_we(s_wb_we), .wb_addr(s_wb_addr), .wb_data(s_wb_data),
    .alloc_we(s_alloc_we), .alloc_addr(s_alloc_addr),
    .clr_req(s_clr_req), .clr_busy(s_clr_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model of the main instance
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  bit          m_clear;
  int          m_idx;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pend  = '0;
    m_clear = 1'b0;
    m_idx   = 0;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (!m_clear && wb_we && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (!m_clear && wb_we && wb_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic void m_edge();
    if (m_clear) begin
      m_regs[m_idx] = '0;
      m_pend[m_idx] = 1'b0;
      m_idx++;
      if (m_idx == 32) m_clear = 1'b0;
    end else begin
      if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      if (wb_we) m_pend[wb_addr] = 1'b0;
      if (alloc_we && alloc_addr != 5'd0) m_pend[alloc_addr] = 1'b1;
      if (clr_req) begin
        m_clear = 1'b1;
        m_idx   = 0;
      end
    end
  endfunction

  // Directed vector table
  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        alloc_we;
    logic [4:0]  alloc_addr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic aw, input logic [4:0] aa,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic eb1, input logic eb2);
    vec_t v;
    v.wb_we = we; v.wb_addr = wa; v.wb_data = wd;
    v.alloc_we = aw; v.alloc_addr = aa;
    v.rs1 = r1; v.rs2 = r2;
    v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
    tbl.push_back(v);
  endfunction

  task automatic idle_inputs();
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    alloc_we = 1'b0; alloc_addr = '0; clr_req = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    s_wb_we = 1'b0; s_wb_addr = '0; s_wb_data = '0;
    s_alloc_we = 1'b0; s_alloc_addr = '0; s_clr_req = 1'b0;
    s_rs1_addr = '0; s_rs2_addr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    idle_inputs();
    m_reset();
    do_reset();

    // Reset state: every address reads zero and not busy
    #1;
    chk("reset clr_busy", 64'(clr_busy), 64'(0));
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      chk("reset rs1_data", 64'(rs1_data), 64'(0));
      chk("reset rs2_data", 64'(rs2_data), 64'(0));
      chk("reset rs1_busy", 64'(rs1_busy), 64'(0));
      chk("reset rs2_busy", 64'(rs2_busy), 64'(0));
    end

    // Table: bypass, r0 behaviour, scoreboard set/clear/priority
    //    we wa     wd            aw aa    r1    r2    e1            e2            b1    b2
    add(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    add(0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        0, 0);
    add(1, 5'd0, 32'h12345678, 0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 0, 0);
    add(0, 5'd0, 32'h0,        1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        0, 0);
    add(0, 5'd0, 32'h0,        1, 5'd7, 5'd0, 5'd7, 32'h0,        32'h0,        0, 0);
    add(0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h0,        0, 1);
    add(1, 5'd7, 32'h55,       0, 5'd0, 5'd7, 5'd7, 32'h55,       32'h55,       0, 0);
    add(0, 5'd0, 32'h0,        0, 5'd0, 5'd7, 5'd7, 32'h55,       32'h55,       0, 0);
    add(1, 5'd9, 32'hAA,       1, 5'd9, 5'd9, 5'd9, 32'hAA,       32'hAA,       0, 0);
    add(0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd9, 32'hAA,       32'hAA,       1, 1);
    add(1, 5'd9, 32'hBB,       0, 5'd0, 5'd9, 5'd5, 32'hBB,       32'hDEADBEEF, 0, 0);
    add(0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd7, 32'hBB,       32'h55,       0, 0);
    add(0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      wb_we = tbl[i].wb_we; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data;
      alloc_we = tbl[i].alloc_we; alloc_addr = tbl[i].alloc_addr;
      rs1_addr = tbl[i].rs1; rs2_addr = tbl[i].rs2;
      #1;
      chk($sformatf("vec%0d rs1_data", i), 64'(rs1_data), 64'(tbl[i].e1));
      chk($sformatf("vec%0d rs2_data", i), 64'(rs2_data), 64'(tbl[i].e2));
      chk($sformatf("vec%0d rs1_busy", i), 64'(rs1_busy), 64'(tbl[i].eb1));
      chk($sformatf("vec%0d rs2_busy", i), 64'(rs2_busy), 64'(tbl[i].eb2));
    end

    // Bulk clear: fill r1..r31 with their index, mark r4 pending, then clear
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      wb_we = 1'b1; wb_addr = 5'(i); wb_data = 32'(i);
      alloc_we = (i == 31); alloc_addr = 5'd4;
    end
    @(negedge clk);
    wb_we = 1'b0; alloc_we = 1'b0;
    rs1_addr = 5'd4; rs2_addr = 5'd17;
    #1;
    chk("fill r4 busy", 64'(rs1_busy), 64'(1));
    chk("fill r17 data", 64'(rs2_data), 64'(17));
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      wb_we = 1'b0;
      if (k == 10) begin
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hFFFF_FFFF;
        rs1_addr = 5'd3; rs2_addr = 5'd20;
      end else if (k == 16) begin
        wb_we = 1'b1; wb_addr = 5'd31; wb_data = 32'hCAFE_F00D;
        rs1_addr = 5'd31; rs2_addr = 5'd1;
      end
      #1;
      if (!clr_busy) break;
      n++;
      if (k == 10) begin
        chk("clear r3 mid", 64'(rs1_data), 64'(0));
        chk("clear r20 not yet", 64'(rs2_data), 64'(20));
      end
      if (k == 16) begin
        chk("clear no bypass r31", 64'(rs1_data), 64'(31));
        chk("clear r1 cleared", 64'(rs2_data), 64'(0));
      end
      @(negedge clk);
    end
    wb_we = 1'b0;
    chk("clr_busy cycles", 64'(n), 64'(32));
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(i);
      #1;
      chk($sformatf("post-clear r%0d data", i), 64'(rs1_data), 64'(0));
      chk($sformatf("post-clear r%0d busy", i), 64'(rs2_busy), 64'(0));
    end

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      wb_we      = ($urandom_range(0, 1) == 1);
      wb_addr    = 5'($urandom_range(0, 31));
      wb_data    = $urandom;
      alloc_we   = ($urandom_range(0, 9) < 4);
      alloc_addr = 5'($urandom_range(0, 31));
      clr_req    = ($urandom_range(0, 99) == 0);
      rs1_addr   = ($urandom_range(0, 3) == 0) ? wb_addr : 5'($urandom_range(0, 31));
      rs2_addr   = ($urandom_range(0, 3) == 0) ? alloc_addr : 5'($urandom_range(0, 31));
      #1;
      chk("rand rs1_data", 64'(rs1_data), 64'(m_rd(rs1_addr)));
      chk("rand rs2_data", 64'(rs2_data), 64'(m_rd(rs2_addr)));
      chk("rand rs1_busy", 64'(rs1_busy), 64'(m_busy(rs1_addr)));
      chk("rand rs2_busy", 64'(rs2_busy), 64'(m_busy(rs2_addr)));
      chk("rand clr_busy", 64'(clr_busy), 64'(m_clear));
      @(posedge clk);
      m_edge();
      @(negedge clk);
    end

    // Reset asserted in the middle of a clear
    do_reset();
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 5'd20; wb_data = 32'h20;
    alloc_we = 1'b1; alloc_addr = 5'd21;
    @(negedge clk);
    wb_we = 1'b0; alloc_we = 1'b0;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    rs1_addr = 5'd20; rs2_addr = 5'd21;
    repeat (4) @(negedge clk);
    #1;
    chk("pre-abort clr_busy", 64'(clr_busy), 64'(1));
    chk("pre-abort r20", 64'(rs1_data), 64'(32'h20));
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort clr_busy", 64'(clr_busy), 64'(0));
    chk("abort r20", 64'(rs1_data), 64'(0));
    chk("abort r21 busy", 64'(rs2_busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("after abort clr_busy", 64'(clr_busy), 64'(0));

    // Swept instance: no bypass, write visible only after the edge
    @(negedge clk);
    s_wb_we = 1'b1; s_wb_addr = 4'd3; s_wb_data = 64'h0123_4567_89AB_CDEF;
    s_alloc_we = 1'b1; s_alloc_addr = 4'd3;
    s_rs1_addr = 4'd3; s_rs2_addr = 4'd3;
    #1;
    chk("sweep same-cycle old", s_rs1_data, 64'(0));
    chk("sweep same-cycle busy", 64'(s_rs2_busy), 64'(0));
    @(negedge clk);
    s_wb_we = 1'b0; s_alloc_we = 1'b0;
    #1;
    chk("sweep next-cycle new", s_rs1_data, 64'h0123_4567_89AB_CDEF);
    chk("sweep alloc wins", 64'(s_rs2_busy), 64'(1));
    @(negedge clk);
    s_wb_we = 1'b1; s_wb_addr = 4'd3; s_wb_data = 64'hFEDC_BA98_7654_3210;
    #1;
    chk("sweep wb-cycle old", s_rs1_data, 64'h0123_4567_89AB_CDEF);
    chk("sweep wb-cycle busy", 64'(s_rs2_busy), 64'(1));
    @(negedge clk);
    s_wb_we = 1'b1; s_wb_addr = 4'd0; s_wb_data = 64'h1111_2222_3333_4444;
    #1;
    chk("sweep new value", s_rs1_data, 64'hFEDC_BA98_7654_3210);
    chk("sweep busy cleared", 64'(s_rs2_busy), 64'(0));
    @(negedge clk);
    s_wb_we = 1'b0;
    s_rs2_addr = 4'd0;
    #1;
    chk("sweep r0 zero", s_rs2_data, 64'(0));
    s_clr_req = 1'b1;
    @(negedge clk);
    s_clr_req = 1'b0;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      #1;
      if (!s_clr_busy) break;
      n++;
      @(negedge clk);
    end
    chk("sweep clr_busy cycles", 64'(n), 64'(16));
    chk("sweep r3 cleared", s_rs1_data, 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
